vending_machine: RTL and testbench

Coin-operated vending controller for a 10-item machine on a button/switch/7-segment/LED board. Coin switches add credit. L/R buttons move the item selection, and C buys the selected item. Price and credit are shown on a multiplexed 8-digit 7-segment display; the selection and vend indication are shown on 10 LEDs.

---
 rtl/vending_machine.sv | 167 ++++++++++++++++
 tb/tb_vending_machine.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine.sv
// vending_machine: coin-operated controller for a 10-item vending board.
//   Coins add credit, L/R step the item selection, C buys the selected item.
//   Price (digits 7..4) and credit (digits 3..0) are shown on a multiplexed
//   8-digit 7-segment display; LEDs show the selection or a vend flash.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   L_button  in   move selection left (level, edge-detected)
//   R_button  in   move selection right (level, edge-detected)
//   C_button  in   purchase selected item (level, edge-detected)
//   switch    in   [4] coin inputs: [0]=10 [1]=50 [2]=100 [3]=500
//   DIGIT     out  [8] active-low one-hot digit enable, bit 7 leftmost
//   SEG       out  [7] active-low segments {g,f,e,d,c,b,a}
//   LED       out  [10] one-hot selection, all-on while vending
module vending_machine #(
  parameter int SCAN_DIV    = 4,
  parameter int VEND_CYCLES = 8,
  parameter int CREDIT_MAX  = 9990
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       L_button,
  input  logic       R_button,
  input  logic       C_button,
  input  logic [3:0] switch,
  output logic [7:0] DIGIT,
  output logic [6:0] SEG,
  output logic [9:0] LED
);

  localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [7:0]      VEND_W   = 8'(VEND_CYCLES);
  localparam logic [14:0]     MAX_W    = 15'(CREDIT_MAX);

  // Previous-cycle copies of the level inputs for rising-edge detection.
  logic       l_p0, r_p0, c_p0;
  logic [3:0] sw_p0;

  logic [13:0]      credit;
  logic [3:0]       sel;
  logic [7:0]       timer;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       scan_idx;

  logic        l_ev, r_ev, c_ev;
  logic [3:0]  sw_ev;
  logic [13:0] coin_sum, credit_coin, credit_ref, credit_next, price;
  logic        buy;
  logic [3:0]  sel_next;
  logic [7:0]  timer_next;
  logic [2:0]  idx_next;
  logic [31:0] disp;

  function automatic logic [13:0] coin_value(input logic [3:0] ev);
    logic [13:0] s;
    s = 14'd0;
    if (ev[0]) s = s + 14'd10;
    if (ev[1]) s = s + 14'd50;
    if (ev[2]) s = s + 14'd100;
    if (ev[3]) s = s + 14'd500;
    return s;
  endfunction

  // Whole-cycle rejection: if the sum would overflow the cap, nothing is added.
  function automatic logic [13:0] add_coins(input logic [13:0] cr, input logic [13:0] sum);
    logic [14:0] total;
    total = {1'b0, cr} + {1'b0, sum};
    return (total > MAX_W) ? cr : total[13:0];
  endfunction

  function automatic logic [13:0] price_of(input logic [3:0] s);
    return 14'd100 + 14'(s) * 14'd50;
  endfunction

  // Double-dabble binary to 4-digit BCD.
  function automatic logic [15:0] to_bcd(input logic [13:0] bin);
    logic [29:0] sh;
    sh = {16'd0, bin};
    for (int i = 0; i < 14; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (sh[14+4*d +: 4] >= 4'd5) sh[14+4*d +: 4] = sh[14+4*d +: 4] + 4'd3;
      end
      sh = sh << 1;
    end
    return sh[29:14];
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  always_comb begin
    l_ev  = L_button & ~l_p0;
    r_ev  = R_button & ~r_p0;
    c_ev  = C_button & ~c_p0;
    sw_ev = switch & ~sw_p0;

    // Coins first, then refund, then the purchase check on the result.
    coin_sum    = coin_value(sw_ev);
    credit_coin = add_coins(credit, coin_sum);
    credit_ref  = (l_ev && r_ev) ? 14'd0 : credit_coin;
    // Purchase prices against the selection held before any move this cycle.
    price       = price_of(sel);
    buy         = c_ev && (credit_ref >= price);
    credit_next = buy ? credit_ref - price : credit_ref;

    sel_next = sel;
    if (l_ev && !r_ev)      sel_next = (sel == 4'd0) ? 4'd9 : sel - 4'd1;
    else if (r_ev && !l_ev) sel_next = (sel == 4'd9) ? 4'd0 : sel + 4'd1;

    timer_next = 8'd0;
    if (buy)                timer_next = VEND_W;
    else if (timer != 8'd0) timer_next = timer - 8'd1;

    idx_next = (div_cnt == DIV_LAST) ? scan_idx + 3'd1 : scan_idx;
    disp     = {to_bcd(price), to_bcd(credit)};
  end

  always_comb begin
    LED = 10'd1 << sel;
    if (timer != 8'd0) LED = '1;
  end

  // ---- state update: edge history, credit/selection/vend, display scan ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l_p0     <= 1'b0;
      r_p0     <= 1'b0;
      c_p0     <= 1'b0;
      sw_p0    <= 4'd0;
      credit   <= 14'd0;
      sel      <= 4'd0;
      timer    <= 8'd0;
      div_cnt  <= '0;
      scan_idx <= 3'd0;
      DIGIT    <= 8'b11111110;
      SEG      <= 7'b1000000;
    end else begin
      l_p0     <= L_button;
      r_p0     <= R_button;
      c_p0     <= C_button;
      sw_p0    <= switch;
      credit   <= credit_next;
      sel      <= sel_next;
      timer    <= timer_next;
      div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      scan_idx <= idx_next;
      // Enable and pattern come from the same index so they always agree.
      DIGIT    <= ~(8'd1 << idx_next);
      SEG      <= seg_of(disp[{idx_next, 2'b00} +: 4]);
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
module tb_vending_machine;
  localparam int SCAN_DIV    = 4;
  localparam int VEND_CYCLES = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       L_button = 1'b0;
  logic       R_button = 1'b0;
  logic       C_button = 1'b0;
  logic [3:0] switch = 4'd0;
  logic [7:0] DIGIT;
  logic [6:0] SEG;
  logic [9:0] LED;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  vending_machine #(.SCAN_DIV(SCAN_DIV), .VEND_CYCLES(VEND_CYCLES), .CREDIT_MAX(9990)) dut (
    .clk(clk), .rst(rst), .L_button(L_button), .R_button(R_button), .C_button(C_button),
    .switch(switch), .DIGIT(DIGIT), .SEG(SEG), .LED(LED)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic l, input logic r, input logic c, input logic [3:0] sw);
    L_button = l; R_button = r; C_button = c; switch = sw;
    cycles(3);
    L_button = 1'b0; R_button = 1'b0; C_button = 1'b0; switch = 4'd0;
    cycles(2);
  endtask

  function automatic int seg_to_digit(input logic [6:0] s);
    for (int k = 0; k < 10; k++) if (seg_tab[k] == s) return k;
    return 15;
  endfunction

  // Scans the multiplexed display until every digit has been seen once.
  task automatic read_display(output int price, output int credit);
    int dig [8];
    logic [7:0] seen;
    int n;
    for (int i = 0; i < 8; i++) dig[i] = 0;
    seen = 8'd0;
    n = 0;
    cycles(2);
    while (seen != 8'hFF && n < 16 * SCAN_DIV + 8) begin
      for (int i = 0; i < 8; i++) begin
        if (DIGIT == ~(8'd1 << i)) begin
          dig[i] = seg_to_digit(SEG);
          seen[i] = 1'b1;
        end
      end
      cycles(1);
      n++;
    end
    check("display_all_digits_seen", int'(seen), 255);
    price  = dig[7] * 1000 + dig[6] * 100 + dig[5] * 10 + dig[4];
    credit = dig[3] * 1000 + dig[2] * 100 + dig[1] * 10 + dig[0];
  endtask

  task automatic vend_count(output int n);
    C_button = 1'b1;
    cycles(1);
    n = 0;
    while (LED == 10'h3FF && n < 50) begin
      n++;
      C_button = 1'b0;
      cycles(1);
    end
    C_button = 1'b0;
  endtask

  initial begin
    int p, c, n;
    int exp_dig [8] = '{0, 3, 2, 1, 0, 0, 2, 0};

    // Reset state
    cycles(3);
    check("reset_led", int'(LED), 'h001);
    check("reset_digit", int'(DIGIT), 'hFE);
    check("reset_seg", int'(SEG), 'h40);
    rst = 1'b1;
    read_display(p, c);
    check("init_price", p, 100);
    check("init_credit", c, 0);

    // Coins
    repeat (3) pulse(0, 0, 0, 4'b0100);
    read_display(p, c);
    check("credit_300", c, 300);
    pulse(0, 0, 0, 4'b1111);
    read_display(p, c);
    check("credit_960_all_coins", c, 960);

    // Refund keeps selection
    pulse(1, 1, 0, 4'b0000);
    read_display(p, c);
    check("refund_credit", c, 0);
    check("refund_led", int'(LED), 'h001);

    // Selection right x3
    repeat (3) pulse(0, 0, 0, 4'b0100);
    repeat (3) pulse(0, 1, 0, 4'b0000);
    check("sel3_led", int'(LED), 'h008);
    read_display(p, c);
    check("sel3_price", p, 250);
    check("sel3_credit", c, 300);

    // Purchase
    vend_count(n);
    check("vend_length", n, VEND_CYCLES);
    check("after_vend_led", int'(LED), 'h008);
    read_display(p, c);
    check("after_buy_credit", c, 50);
    pulse(0, 0, 1, 4'b0000);
    check("no_buy_led", int'(LED), 'h008);
    read_display(p, c);
    check("no_buy_credit", c, 50);

    // Selection left x4 wraps to 9
    repeat (4) pulse(1, 0, 0, 4'b0000);
    check("sel9_led", int'(LED), 'h200);
    read_display(p, c);
    check("sel9_price", p, 550);

    // Saturation
    repeat (19) pulse(0, 0, 0, 4'b1000);
    repeat (2) pulse(0, 0, 0, 4'b0100);
    pulse(0, 0, 0, 4'b0010);
    read_display(p, c);
    check("credit_9800", c, 9800);
    pulse(0, 0, 0, 4'b1000);
    read_display(p, c);
    check("reject_500", c, 9800);
    pulse(0, 0, 0, 4'b0100);
    pulse(0, 0, 0, 4'b0010);
    repeat (4) pulse(0, 0, 0, 4'b0001);
    read_display(p, c);
    check("credit_at_max", c, 9990);
    pulse(0, 0, 0, 4'b0001);
    read_display(p, c);
    check("reject_over_max", c, 9990);
    pulse(1, 1, 0, 4'b0000);
    read_display(p, c);
    check("refund_from_max", c, 0);
    check("refund_keeps_sel9", int'(LED), 'h200);

    // Coin and purchase in the same cycle: 550 inserted, price 550
    pulse(0, 0, 1, 4'b1010);
    check("coin_then_buy_led", int'(LED), 'h3FF);
    read_display(p, c);
    check("coin_then_buy_credit", c, 0);

    // Reset during a vend
    pulse(0, 0, 1, 4'b1010);
    check("vend_before_reset", int'(LED), 'h3FF);
    rst = 1'b0;
    #1;
    check("midreset_led", int'(LED), 'h001);
    check("midreset_digit", int'(DIGIT), 'hFE);
    check("midreset_seg", int'(SEG), 'h40);
    cycles(2);
    rst = 1'b1;
    read_display(p, c);
    check("post_reset_price", p, 100);
    check("post_reset_credit", c, 0);

    // Scan sequence with credit 1230, price 200
    repeat (2) pulse(0, 0, 0, 4'b1000);
    repeat (2) pulse(0, 0, 0, 4'b0100);
    repeat (3) pulse(0, 0, 0, 4'b0001);
    repeat (2) pulse(0, 1, 0, 4'b0000);
    read_display(p, c);
    check("scan_setup_credit", c, 1230);
    check("scan_setup_price", p, 200);
    n = 0;
    while (DIGIT != 8'h7F && n < 100) begin cycles(1); n++; end
    while (DIGIT != 8'hFE && n < 100) begin cycles(1); n++; end
    check("scan_align", int'(DIGIT), 'hFE);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] ed;
      ed = ~(8'd1 << k);
      check($sformatf("scan_digit_%0d", k), int'(DIGIT), int'(ed));
      check($sformatf("scan_seg_%0d", k), int'(SEG), int'(seg_tab[exp_dig[k]]));
      cycles(SCAN_DIV);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
